// File: rtl/hazard_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_control_unit_pkg
//   Shared encodings for the hazard control unit of the 5-stage MIPS core:
//   forwarding-select codes, FSM state encoding, the hard-wired zero
//   register, and a helper that decides whether a later pipeline stage
//   produces a value that an EX-stage operand must pick up.
// ---------------------------------------------------------------------------
package hazard_control_unit_pkg;

   // Forwarding mux select codes for an EX-stage ALU operand
   localparam logic [1:0] FWD_REG   = 2'b00;  // register file read data
   localparam logic [1:0] FWD_EXMEM = 2'b10;  // EX/MEM ALU result
   localparam logic [1:0] FWD_MEMWB = 2'b01;  // MEM/WB write-back data

   // $0 is hard-wired; it is never a real hazard or forwarding source
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Load-use FSM states
   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } hcu_state_e;

   // True when a stage that writes register dest produces the value that
   // an operand reading register src needs.
   function automatic logic reg_match(input logic       i_we,
                                      input logic [4:0] i_dest,
                                      input logic [4:0] i_src);
      return i_we && (i_dest != REG_ZERO) && (i_dest == i_src);
   endfunction

endpackage

// File: rtl/hazard_control_unit_forward_select.sv
// ---------------------------------------------------------------------------
// hazard_control_unit_forward_select
//   Forwarding select for one EX-stage operand (instantiated once for rs ->
//   ForwardA and once for rt -> ForwardB). Purely combinational.
// Ports
//   i_ex_src        source register held in ID/EX for this operand
//   i_mem_reg_write EX/MEM instruction writes the register file
//   i_mem_dest_reg  EX/MEM destination register
//   i_wb_reg_write  MEM/WB instruction writes the register file
//   i_wb_dest_reg   MEM/WB destination register
//   o_fwd_sel       FWD_REG / FWD_EXMEM / FWD_MEMWB
// ---------------------------------------------------------------------------
module hazard_control_unit_forward_select
   import hazard_control_unit_pkg::*;
(
   input  logic [4:0] i_ex_src,
   input  logic       i_mem_reg_write,
   input  logic [4:0] i_mem_dest_reg,
   input  logic       i_wb_reg_write,
   input  logic [4:0] i_wb_dest_reg,
   output logic [1:0] o_fwd_sel
);

   logic w_mem_hit;
   logic w_wb_hit;

   assign w_mem_hit = reg_match(i_mem_reg_write, i_mem_dest_reg, i_ex_src);
   assign w_wb_hit  = reg_match(i_wb_reg_write,  i_wb_dest_reg,  i_ex_src);

   // EX/MEM holds the younger write, so it wins when both stages match.
   always_comb begin
      o_fwd_sel = FWD_REG;
      if (w_mem_hit) begin
         o_fwd_sel = FWD_EXMEM;
      end else if (w_wb_hit) begin
         o_fwd_sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
//   Consumer-side pipeline control for the 5-stage MIPS core.
//   - Load-use hazard: holds PC and IF/ID and injects a bubble into ID/EX for
//     LOAD_STALL_CYCLES cycles (legal range 1..7).
//   - Taken branch/jump resolved in MEM: flushes IF/ID, ID/EX and EX/MEM and
//     steers the PC to the target. A flush aborts any stall in progress.
//   - EX-stage forwarding selects for both ALU operands.
//   - Saturating debug counters of stall cycles and flush events.
// Parameters
//   LOAD_STALL_CYCLES  bubbles per load-use hazard (1..7)
//   CNT_W              width of the two performance counters
// Ports
//   i_clock, i_reset                  clock, asynchronous active-high reset
//   i_id_rs/rt, i_id_uses_rs/rt       decode-stage source fields and usage
//   i_ex_rs/rt                        ID/EX source registers (forwarding)
//   i_ex_r_enable, i_ex_reg_write,
//   i_ex_dest_reg                     ID/EX load flag, write enable, dest
//   i_mem_reg_write, i_mem_dest_reg   EX/MEM write enable and dest
//   i_mem_branch_taken                branch/jump taken in MEM this cycle
//   i_wb_reg_write, i_wb_dest_reg     MEM/WB write enable and dest
//   o_pc_write, o_ifid_write          stage enables (1 = may update)
//   o_ifid_flush, o_idex_flush,
//   o_exmem_flush                     flush/bubble requests
//   o_pc_src                          1 = PC takes the branch target
//   o_forward_a, o_forward_b          EX operand forwarding selects
//   o_stall_count, o_flush_count      saturating debug counters
//   o_dbg_state, o_dbg_rem,
//   o_dbg_hazard                      FSM state, remaining stall count, raw hz
//
// Interface timing: every output is a level that is valid throughout the
// cycle in which the inputs that produce it are stable; the pipeline samples
// them on the next rising edge. There is no request/acknowledge handshake.
// ---------------------------------------------------------------------------
module hazard_control_unit
   import hazard_control_unit_pkg::*;
#(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int CNT_W             = 32
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [4:0]       i_id_rs,
   input  logic [4:0]       i_id_rt,
   input  logic             i_id_uses_rs,
   input  logic             i_id_uses_rt,
   input  logic [4:0]       i_ex_rs,
   input  logic [4:0]       i_ex_rt,
   input  logic             i_ex_r_enable,
   input  logic             i_ex_reg_write,
   input  logic [4:0]       i_ex_dest_reg,
   input  logic             i_mem_reg_write,
   input  logic [4:0]       i_mem_dest_reg,
   input  logic             i_mem_branch_taken,
   input  logic             i_wb_reg_write,
   input  logic [4:0]       i_wb_dest_reg,
   output logic             o_pc_write,
   output logic             o_ifid_write,
   output logic             o_ifid_flush,
   output logic             o_idex_flush,
   output logic             o_exmem_flush,
   output logic             o_pc_src,
   output logic [1:0]       o_forward_a,
   output logic [1:0]       o_forward_b,
   output logic [CNT_W-1:0] o_stall_count,
   output logic [CNT_W-1:0] o_flush_count,
   output hcu_state_e       o_dbg_state,
   output logic [2:0]       o_dbg_rem,
   output logic             o_dbg_hazard
);

   // The first stall cycle is spent in RUN, so STALL covers the remaining
   // LOAD_STALL_CYCLES-1 cycles; rem counts down to 0 on the last of them.
   localparam logic       MULTI_STALL = (LOAD_STALL_CYCLES > 1);
   localparam logic [2:0] REM_INIT    = MULTI_STALL ? 3'(LOAD_STALL_CYCLES - 2) : 3'd0;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   hcu_state_e       r_state;
   logic [2:0]       r_rem;
   logic [CNT_W-1:0] r_stall_count;
   logic [CNT_W-1:0] r_flush_count;

   logic       w_hz;
   logic       w_stall;
   logic       w_pc_write;
   logic       w_ifid_write;
   logic       w_ifid_flush;
   logic       w_idex_flush;
   logic       w_exmem_flush;
   logic       w_pc_src;
   logic [1:0] w_fwd_a;
   logic [1:0] w_fwd_b;

   // Load-use hazard: the load in EX writes a register the decode
   // instruction actually reads.
   assign w_hz = i_ex_r_enable && i_ex_reg_write && (i_ex_dest_reg != REG_ZERO) &&
                 ((i_id_uses_rs && (i_ex_dest_reg == i_id_rs)) ||
                  (i_id_uses_rt && (i_ex_dest_reg == i_id_rt)));

   // A taken branch kills the instruction that would otherwise be stalled,
   // so it masks both a fresh hazard and an in-progress stall.
   assign w_stall = !i_mem_branch_taken && ((r_state == STALL) || w_hz);

   // ------------------------------------------------------------------
   // Pipeline control outputs (combinational so a hazard stalls in the
   // same cycle it is detected; reset forces them without a clock)
   // ------------------------------------------------------------------
   always_comb begin
      w_pc_write    = 1'b1;
      w_ifid_write  = 1'b1;
      w_ifid_flush  = 1'b0;
      w_idex_flush  = 1'b0;
      w_exmem_flush = 1'b0;
      w_pc_src      = 1'b0;
      if (i_reset) begin
         w_pc_write    = 1'b0;
         w_ifid_write  = 1'b0;
         w_ifid_flush  = 1'b1;
         w_idex_flush  = 1'b1;
         w_exmem_flush = 1'b1;
      end else if (i_mem_branch_taken) begin
         w_ifid_flush  = 1'b1;
         w_idex_flush  = 1'b1;
         w_exmem_flush = 1'b1;
         w_pc_src      = 1'b1;
      end else if (w_stall) begin
         w_pc_write    = 1'b0;
         w_ifid_write  = 1'b0;
         w_idex_flush  = 1'b1;
      end
   end

   assign o_pc_write    = w_pc_write;
   assign o_ifid_write  = w_ifid_write;
   assign o_ifid_flush  = w_ifid_flush;
   assign o_idex_flush  = w_idex_flush;
   assign o_exmem_flush = w_exmem_flush;
   assign o_pc_src      = w_pc_src;

   // ------------------------------------------------------------------
   // Forwarding
   // ------------------------------------------------------------------
   hazard_control_unit_forward_select u_fwd_a (
      .i_ex_src        (i_ex_rs),
      .i_mem_reg_write (i_mem_reg_write),
      .i_mem_dest_reg  (i_mem_dest_reg),
      .i_wb_reg_write  (i_wb_reg_write),
      .i_wb_dest_reg   (i_wb_dest_reg),
      .o_fwd_sel       (w_fwd_a)
   );

   hazard_control_unit_forward_select u_fwd_b (
      .i_ex_src        (i_ex_rt),
      .i_mem_reg_write (i_mem_reg_write),
      .i_mem_dest_reg  (i_mem_dest_reg),
      .i_wb_reg_write  (i_wb_reg_write),
      .i_wb_dest_reg   (i_wb_dest_reg),
      .o_fwd_sel       (w_fwd_b)
   );

   assign o_forward_a = i_reset ? FWD_REG : w_fwd_a;
   assign o_forward_b = i_reset ? FWD_REG : w_fwd_b;

   // ------------------------------------------------------------------
   // Load-use stall FSM
   // ------------------------------------------------------------------
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= RUN;
         r_rem   <= 3'd0;
      end else if (i_mem_branch_taken) begin
         r_state <= RUN;
         r_rem   <= 3'd0;
      end else begin
         case (r_state)
            RUN: begin
               if (w_hz && MULTI_STALL) begin
                  r_state <= STALL;
                  r_rem   <= REM_INIT;
               end
            end
            STALL: begin
               if (r_rem == 3'd0) begin
                  r_state <= RUN;
               end else begin
                  r_rem <= r_rem - 3'd1;
               end
            end
            default: begin
               r_state <= RUN;
               r_rem   <= 3'd0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Saturating debug counters
   // ------------------------------------------------------------------
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_stall_count <= '0;
         r_flush_count <= '0;
      end else begin
         if (!w_pc_write && (r_stall_count != CNT_MAX)) begin
            r_stall_count <= r_stall_count + CNT_ONE;
         end
         if (i_mem_branch_taken && (r_flush_count != CNT_MAX)) begin
            r_flush_count <= r_flush_count + CNT_ONE;
         end
      end
   end

   assign o_stall_count = r_stall_count;
   assign o_flush_count = r_flush_count;

   assign o_dbg_state  = r_state;
   assign o_dbg_rem    = r_rem;
   assign o_dbg_hazard = w_hz;

endmodule

// File: tb/tb_hazard_control_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_control_unit
//   Two instances share one input stimulus:
//     dut_a : LOAD_STALL_CYCLES = 1, CNT_W = 32
//     dut_b : LOAD_STALL_CYCLES = 3, CNT_W = 4   (multi-cycle stall, saturation)
//   The driver applies inputs on the falling edge, runs the reference model
//   and pushes the expected outputs; one monitor per instance pops and
//   compares two time units later.
// ---------------------------------------------------------------------------
module tb_hazard_control_unit;
   import hazard_control_unit_pkg::*;

   typedef struct packed {
      logic        pcw;
      logic        ifidw;
      logic        ifidf;
      logic        idexf;
      logic        exmemf;
      logic        pcsrc;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   localparam int EXP_W = $bits(exp_t);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
   logic       id_uses_rs, id_uses_rt, ex_r_en, ex_rw, mem_rw, br, wb_rw;

   // staged values, applied on the next falling edge by step()
   logic       s_rst;
   logic [4:0] s_id_rs, s_id_rt, s_ex_rs, s_ex_rt, s_ex_dest, s_mem_dest, s_wb_dest;
   logic       s_id_uses_rs, s_id_uses_rt, s_ex_r_en, s_ex_rw, s_mem_rw, s_br, s_wb_rw;

   // ---------------- DUT outputs ----------------
   logic        a_pcw, a_ifidw, a_ifidf, a_idexf, a_exmemf, a_pcsrc, a_hz;
   logic [1:0]  a_fa, a_fb;
   logic [31:0] a_sc, a_fc;
   logic [2:0]  a_rem;
   hcu_state_e  a_state;

   logic        b_pcw, b_ifidw, b_ifidf, b_idexf, b_exmemf, b_pcsrc, b_hz;
   logic [1:0]  b_fa, b_fb;
   logic [3:0]  b_sc, b_fc;
   logic [2:0]  b_rem;
   hcu_state_e  b_state;

   hazard_control_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) dut_a (
      .i_clock(clk), .i_reset(rst),
      .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rs(id_uses_rs), .i_id_uses_rt(id_uses_rt),
      .i_ex_rs(ex_rs), .i_ex_rt(ex_rt), .i_ex_r_enable(ex_r_en), .i_ex_reg_write(ex_rw),
      .i_ex_dest_reg(ex_dest), .i_mem_reg_write(mem_rw), .i_mem_dest_reg(mem_dest),
      .i_mem_branch_taken(br), .i_wb_reg_write(wb_rw), .i_wb_dest_reg(wb_dest),
      .o_pc_write(a_pcw), .o_ifid_write(a_ifidw), .o_ifid_flush(a_ifidf),
      .o_idex_flush(a_idexf), .o_exmem_flush(a_exmemf), .o_pc_src(a_pcsrc),
      .o_forward_a(a_fa), .o_forward_b(a_fb),
      .o_stall_count(a_sc), .o_flush_count(a_fc),
      .o_dbg_state(a_state), .o_dbg_rem(a_rem), .o_dbg_hazard(a_hz)
   );

   hazard_control_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) dut_b (
      .i_clock(clk), .i_reset(rst),
      .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rs(id_uses_rs), .i_id_uses_rt(id_uses_rt),
      .i_ex_rs(ex_rs), .i_ex_rt(ex_rt), .i_ex_r_enable(ex_r_en), .i_ex_reg_write(ex_rw),
      .i_ex_dest_reg(ex_dest), .i_mem_reg_write(mem_rw), .i_mem_dest_reg(mem_dest),
      .i_mem_branch_taken(br), .i_wb_reg_write(wb_rw), .i_wb_dest_reg(wb_dest),
      .o_pc_write(b_pcw), .o_ifid_write(b_ifidw), .o_ifid_flush(b_ifidf),
      .o_idex_flush(b_idexf), .o_exmem_flush(b_exmemf), .o_pc_src(b_pcsrc),
      .o_forward_a(b_fa), .o_forward_b(b_fb),
      .o_stall_count(b_sc), .o_flush_count(b_fc),
      .o_dbg_state(b_state), .o_dbg_rem(b_rem), .o_dbg_hazard(b_hz)
   );

   // ---------------- scoreboard ----------------
   logic [EXP_W-1:0] exp_q_a[$];
   logic [EXP_W-1:0] exp_q_b[$];
   int checks   = 0;
   int failures = 0;
   int cycle    = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h exp=%0h", name, cycle, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Per instance: how many more forced stall cycles are owed after the
   // current one, and the counter values as of the last rising edge.
   int              stall_left[2];
   longint unsigned scnt[2];
   longint unsigned fcnt[2];
   int              lsc[2]  = '{1, 3};
   longint unsigned cmax[2] = '{64'hFFFF_FFFF, 64'd15};

   function automatic logic [1:0] ref_fwd(input logic [4:0] src);
      if (mem_rw && mem_dest != 0 && mem_dest == src) return 2'b10;
      if (wb_rw && wb_dest != 0 && wb_dest == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic exp_t model(input int k);
      exp_t e;
      logic hz;
      hz = ex_r_en && ex_rw && ex_dest != 0 &&
           ((id_uses_rs && ex_dest == id_rs) || (id_uses_rt && ex_dest == id_rt));
      e = '0;
      if (rst) begin
         stall_left[k] = 0;
         scnt[k] = 0;
         fcnt[k] = 0;
         {e.ifidf, e.idexf, e.exmemf} = 3'b111;
         return e;
      end
      e.fa = ref_fwd(ex_rs);
      e.fb = ref_fwd(ex_rt);
      if (br) begin
         {e.pcw, e.ifidw, e.ifidf, e.idexf, e.exmemf, e.pcsrc} = 6'b111111;
         stall_left[k] = 0;
      end else if (stall_left[k] > 0) begin
         e.idexf = 1'b1;
         stall_left[k]--;
      end else if (hz) begin
         e.idexf = 1'b1;
         stall_left[k] = lsc[k] - 1;
      end else begin
         {e.pcw, e.ifidw} = 2'b11;
      end
      e.sc = 32'(scnt[k]);
      e.fc = 32'(fcnt[k]);
      // effect of the coming rising edge
      if (!e.pcw && scnt[k] < cmax[k]) scnt[k]++;
      if (br && fcnt[k] < cmax[k]) fcnt[k]++;
      return e;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      s_rst = 1'b0;
      s_id_rs = 5'd1; s_id_rt = 5'd2; s_id_uses_rs = 1'b1; s_id_uses_rt = 1'b1;
      s_ex_rs = 5'd3; s_ex_rt = 5'd4; s_ex_r_en = 1'b0; s_ex_rw = 1'b0; s_ex_dest = 5'd0;
      s_mem_rw = 1'b0; s_mem_dest = 5'd0; s_br = 1'b0; s_wb_rw = 1'b0; s_wb_dest = 5'd0;
   endtask

   task automatic set_load_use(input logic [4:0] dest);
      set_idle();
      s_ex_r_en = 1'b1; s_ex_rw = 1'b1; s_ex_dest = dest;
      s_id_rs = dest; s_id_uses_rs = 1'b1;
   endtask

   task automatic set_random();
      s_rst        = ($urandom_range(0, 99) == 0);
      s_id_rs      = 5'($urandom_range(0, 3));
      s_id_rt      = 5'($urandom_range(0, 3));
      s_id_uses_rs = 1'($urandom_range(0, 1));
      s_id_uses_rt = 1'($urandom_range(0, 1));
      s_ex_rs      = 5'($urandom_range(0, 3));
      s_ex_rt      = 5'($urandom_range(0, 3));
      s_ex_r_en    = 1'($urandom_range(0, 1));
      s_ex_rw      = ($urandom_range(0, 3) != 0);
      s_ex_dest    = 5'($urandom_range(0, 3));
      s_mem_rw     = 1'($urandom_range(0, 1));
      s_mem_dest   = 5'($urandom_range(0, 3));
      s_br         = ($urandom_range(0, 7) == 0);
      s_wb_rw      = 1'($urandom_range(0, 1));
      s_wb_dest    = 5'($urandom_range(0, 3));
   endtask

   // Apply staged inputs on the falling edge and queue the expectations.
   task automatic step();
      @(negedge clk);
      cycle++;
      rst = s_rst;
      id_rs = s_id_rs; id_rt = s_id_rt; id_uses_rs = s_id_uses_rs; id_uses_rt = s_id_uses_rt;
      ex_rs = s_ex_rs; ex_rt = s_ex_rt; ex_r_en = s_ex_r_en; ex_rw = s_ex_rw; ex_dest = s_ex_dest;
      mem_rw = s_mem_rw; mem_dest = s_mem_dest; br = s_br; wb_rw = s_wb_rw; wb_dest = s_wb_dest;
      exp_q_a.push_back(model(0));
      exp_q_b.push_back(model(1));
   endtask

   // ---------------- monitors ----------------
   task automatic cmp_dut(input string t, input exp_t e,
                          input logic pcw, input logic ifidw, input logic ifidf,
                          input logic idexf, input logic exmemf, input logic pcsrc,
                          input logic [1:0] fa, input logic [1:0] fb,
                          input logic [31:0] sc, input logic [31:0] fc);
      check({t, ".pc_write"},    {31'b0, pcw},    {31'b0, e.pcw});
      check({t, ".ifid_write"},  {31'b0, ifidw},  {31'b0, e.ifidw});
      check({t, ".ifid_flush"},  {31'b0, ifidf},  {31'b0, e.ifidf});
      check({t, ".idex_flush"},  {31'b0, idexf},  {31'b0, e.idexf});
      check({t, ".exmem_flush"}, {31'b0, exmemf}, {31'b0, e.exmemf});
      check({t, ".pc_src"},      {31'b0, pcsrc},  {31'b0, e.pcsrc});
      check({t, ".forward_a"},   {30'b0, fa},     {30'b0, e.fa});
      check({t, ".forward_b"},   {30'b0, fb},     {30'b0, e.fb});
      check({t, ".stall_count"}, sc,              e.sc);
      check({t, ".flush_count"}, fc,              e.fc);
   endtask

   initial begin : mon_a
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q_a.size() > 0) begin
            e = exp_t'(exp_q_a.pop_front());
            cmp_dut("a", e, a_pcw, a_ifidw, a_ifidf, a_idexf, a_exmemf, a_pcsrc,
                    a_fa, a_fb, a_sc, a_fc);
         end
      end
   end

   initial begin : mon_b
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q_b.size() > 0) begin
            e = exp_t'(exp_q_b.pop_front());
            cmp_dut("b", e, b_pcw, b_ifidw, b_ifidf, b_idexf, b_exmemf, b_pcsrc,
                    b_fa, b_fb, {28'b0, b_sc}, {28'b0, b_fc});
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog cycle=%0d got=timeout exp=finish", cycle);
      $fatal(1, "simulation time limit reached");
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      set_idle();
      s_rst = 1'b1;
      rst = 1'b1;
      id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; ex_rs = 0; ex_rt = 0;
      ex_r_en = 0; ex_rw = 0; ex_dest = 0; mem_rw = 0; mem_dest = 0; br = 0;
      wb_rw = 0; wb_dest = 0;
      for (int k = 0; k < 2; k++) begin
         stall_left[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      end

      // reset values
      step();
      set_idle();
      step();
      step();

      // load $8 in EX, decode reads rs=$8
      set_load_use(5'd8);
      step();
      set_idle();
      repeat (4) step();

      // load to $0, decode reads $0: no stall
      set_load_use(5'd0);
      step();
      set_idle();
      step();

      // fresh counters, then hazard with a taken branch in the 2nd stall cycle
      s_rst = 1'b1;
      step();
      set_idle();
      step();
      set_load_use(5'd8);
      step();
      set_idle();
      s_br = 1'b1;
      step();
      set_idle();
      repeat (2) step();

      // forwarding priority: EX/MEM over MEM/WB, then MEM/WB alone
      set_idle();
      s_mem_rw = 1'b1; s_wb_rw = 1'b1; s_mem_dest = 5'd5; s_wb_dest = 5'd5; s_ex_rs = 5'd5;
      step();
      s_mem_rw = 1'b0;
      step();
      s_ex_rt = 5'd5; s_wb_dest = 5'd0;
      step();

      // reset asserted on the falling edge while dut_b is stalling
      set_load_use(5'd9);
      step();
      set_idle();
      s_rst = 1'b1;
      step();
      set_idle();
      repeat (3) step();

      // 20 back-to-back taken branches: dut_b flush counter pins at 15
      set_idle();
      s_br = 1'b1;
      repeat (20) step();
      set_idle();
      step();

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         set_random();
         step();
      end
      set_idle();
      repeat (2) step();

      @(negedge clk);
      #4;
      check("queue_a_drained", 32'(exp_q_a.size()), 32'd0);
      check("queue_b_drained", 32'(exp_q_b.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
